// File: rtl/counter_pkg.sv
// Shared mode and state encodings for the up/down counter family.
// The prescaler option is enabled with the COUNTER_PRESCALE_EN macro.
package counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider for updown_counter_mod: ticks once every (prescale+1) enabled cycles.
// Instantiated only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] div_cnt;

   // >= rather than == so a run-time decrease of prescale cannot strand the divider
   assign tick = enable && (div_cnt >= prescale);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt <= '0;
      end else if (enable) begin
         if (div_cnt >= prescale) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, load, and WRAP/SATURATE/ONESHOT modes.
// Define COUNTER_PRESCALE_EN to add the prescale input and an internal enable divider.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load_en,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      max_val,
   input  logic [1:0]            mode,
`ifdef COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0]      count,
   output logic                  pulse,
   output logic                  done
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   if (WIDTH < 2 || PRESCALE_W < 1) begin : g_bad_params
      $error("updown_counter_mod: WIDTH must be >= 2 and PRESCALE_W >= 1");
   end

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                   input logic [WIDTH-1:0] top);
      return (v > top) ? top : v;
   endfunction

   state_t           state;
   logic             sat;
   logic             sat_up;
   logic             cnt_edge;
   logic [WIDTH-1:0] term;

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .clear    (load_en),
      .enable   (enable),
      .prescale (prescale),
      .tick     (cnt_edge)
   );
`else
   assign cnt_edge = enable;
`endif

   assign term = up_down ? max_val : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         pulse  <= 1'b0;
         done   <= 1'b0;
         sat    <= 1'b0;
         sat_up <= 1'b0;
         state  <= ST_RUN;
      end else if (load_en) begin
         count <= clamp_load(load_val, max_val);
         pulse <= 1'b0;
         done  <= 1'b0;
         sat   <= 1'b0;
         state <= ST_RUN;
      end else if (cnt_edge && state == ST_RUN) begin
         pulse <= 1'b0;
         // the saturation latch belongs to one direction; reversing re-arms it
         if (sat_up != up_down) begin
            sat <= 1'b0;
         end
         if (count > max_val) begin
            count <= up_down ? '0 : max_val;
         end else if (count == term) begin
            case (mode)
               MODE_SAT: begin
                  pulse  <= !(sat && (sat_up == up_down));
                  sat    <= 1'b1;
                  sat_up <= up_down;
               end
               MODE_ONESHOT: begin
                  pulse <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
               default: begin
                  count <= up_down ? '0 : max_val;
                  pulse <= 1'b1;
               end
            endcase
         end else begin
            count <= up_down ? (count + ONE) : (count - ONE);
         end
      end else begin
         pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod; covers the prescaler when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_mod;

   localparam int WIDTH      = 8;
   localparam int PRESCALE_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             up_down = 1'b1;
   logic             load_en = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] max_val = '0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] count;
   logic             pulse;
   logic             done;
`ifdef COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale = '0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] c;
      logic             p;
      logic             d;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   updown_counter_mod #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .up_down  (up_down),
      .load_en  (load_en),
      .load_val (load_val),
      .max_val  (max_val),
      .mode     (mode),
`ifdef COUNTER_PRESCALE_EN
      .prescale (prescale),
`endif
      .count    (count),
      .pulse    (pulse),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
   task automatic step(input string tag, input logic r, input logic en, input logic ud,
                       input logic ld, input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] mx,
                       input logic [1:0] md, input logic [WIDTH-1:0] ec, input logic ep,
                       input logic ed);
      exp_t e;
      reset    = r;
      enable   = en;
      up_down  = ud;
      load_en  = ld;
      load_val = lv;
      max_val  = mx;
      mode     = md;
      e.c = ec;
      e.p = ep;
      e.d = ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val({tag, " count"}, 32'(count), 32'(e.c));
      check_val({tag, " pulse"}, 32'(pulse), 32'(e.p));
      check_val({tag, " done"},  32'(done),  32'(e.d));
   endtask

   initial begin
      // reset state
      step("reset", 1, 0, 1, 0, 8'd0, 8'd9, 2'b00, 8'd0, 0, 0);

      // WRAP up, modulus 9
      for (int i = 1; i <= 11; i++)
         step("wrap_up", 0, 1, 1, 0, 8'd0, 8'd9, 2'b00, 8'(i % 10), (i == 10), 0);

      // WRAP down from a load
      step("wrap_dn_ld", 0, 1, 0, 1, 8'd2, 8'd5, 2'b00, 8'd2, 0, 0);
      step("wrap_dn",    0, 1, 0, 0, 8'd0, 8'd5, 2'b00, 8'd1, 0, 0);
      step("wrap_dn",    0, 1, 0, 0, 8'd0, 8'd5, 2'b00, 8'd0, 0, 0);
      step("wrap_dn_tc", 0, 1, 0, 0, 8'd0, 8'd5, 2'b00, 8'd5, 1, 0);
      step("wrap_dn",    0, 1, 0, 0, 8'd0, 8'd5, 2'b00, 8'd4, 0, 0);

      // enable low holds
      step("hold", 0, 0, 0, 0, 8'd0, 8'd5, 2'b00, 8'd4, 0, 0);
      step("hold", 0, 0, 1, 0, 8'd0, 8'd5, 2'b00, 8'd4, 0, 0);

      // WRAP with max_val == 0: every enabled edge is a TC
      step("max0_ld", 0, 0, 1, 1, 8'd0, 8'd0, 2'b00, 8'd0, 0, 0);
      for (int i = 0; i < 3; i++)
         step("max0", 0, 1, 1, 0, 8'd0, 8'd0, 2'b00, 8'd0, 1, 0);

      // count above a reduced max_val is forced in range without a pulse
      step("oor_ld",  0, 0, 1, 1, 8'd8, 8'd9, 2'b00, 8'd8, 0, 0);
      step("oor_up",  0, 1, 1, 0, 8'd0, 8'd5, 2'b00, 8'd0, 0, 0);
      step("oor_ld2", 0, 0, 1, 1, 8'd8, 8'd9, 2'b00, 8'd8, 0, 0);
      step("oor_dn",  0, 1, 0, 0, 8'd0, 8'd5, 2'b00, 8'd5, 0, 0);

      // SATURATE up then down
      step("sat_ld", 0, 0, 1, 1, 8'd0, 8'd3, 2'b01, 8'd0, 0, 0);
      for (int i = 1; i <= 8; i++)
         step("sat_up", 0, 1, 1, 0, 8'd0, 8'd3, 2'b01, 8'((i > 3) ? 3 : i), (i == 4), 0);
      step("sat_dn",    0, 1, 0, 0, 8'd0, 8'd3, 2'b01, 8'd2, 0, 0);
      step("sat_dn",    0, 1, 0, 0, 8'd0, 8'd3, 2'b01, 8'd1, 0, 0);
      step("sat_dn",    0, 1, 0, 0, 8'd0, 8'd3, 2'b01, 8'd0, 0, 0);
      step("sat_dn_tc", 0, 1, 0, 0, 8'd0, 8'd3, 2'b01, 8'd0, 1, 0);
      step("sat_dn",    0, 1, 0, 0, 8'd0, 8'd3, 2'b01, 8'd0, 0, 0);

      // ONESHOT up, then reload
      step("os_ld", 0, 0, 1, 1, 8'd0, 8'd4, 2'b10, 8'd0, 0, 0);
      for (int i = 1; i <= 4; i++)
         step("os_up", 0, 1, 1, 0, 8'd0, 8'd4, 2'b10, 8'(i), 0, 0);
      step("os_tc",     0, 1, 1, 0, 8'd0, 8'd4, 2'b10, 8'd4, 1, 1);
      step("os_hold",   0, 1, 1, 0, 8'd0, 8'd4, 2'b10, 8'd4, 0, 1);
      step("os_hold_d", 0, 1, 0, 0, 8'd0, 8'd4, 2'b10, 8'd4, 0, 1);
      step("os_reld",   0, 1, 1, 1, 8'd1, 8'd4, 2'b10, 8'd1, 0, 0);
      step("os_resume", 0, 1, 1, 0, 8'd0, 8'd4, 2'b10, 8'd2, 0, 0);

      // reset priority, load clamp, reset out of DONE
      step("rst_ld_en", 1, 1, 1, 1, 8'd7,   8'd50, 2'b00, 8'd0,  0, 0);
      step("ld_clamp",  0, 0, 1, 1, 8'd200, 8'd50, 2'b10, 8'd50, 0, 0);
      step("os_tc50",   0, 1, 1, 0, 8'd0,   8'd50, 2'b10, 8'd50, 1, 1);
      step("rst_done",  1, 0, 1, 0, 8'd0,   8'd50, 2'b10, 8'd0,  0, 0);

`ifdef COUNTER_PRESCALE_EN
      // prescale=2: one counting edge per 3 enabled cycles
      prescale = 4'd2;
      step("ps_ld", 0, 1, 1, 1, 8'd0, 8'd1, 2'b00, 8'd0, 0, 0);
      for (int i = 1; i <= 7; i++)
         step("ps_up", 0, 1, 1, 0, 8'd0, 8'd1, 2'b00, 8'((i >= 3 && i < 6) ? 1 : 0), (i == 6), 0);
      prescale = 4'd0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
